ddr2_line_bridge: RTL and testbench

- Sits directly downstream of the data cache.
- Converts the cache's 128-bit line requests into MIG-style DDR2 user-interface transactions: one fill read per `ddr2_enable` with `ddr2_read=1`, one writeback per `ddr2_enable` with `ddr2_read=0`.
- Buffers up to two requests, so a writeback followed on the next cycle by a fill read is never lost.
- Returns fill data with a single-cycle `ddr2_available` pulse.

---
 rtl/ddr2_line_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_ddr2_line_bridge.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_line_bridge.sv
// ddr2_line_bridge
//   Bridges 128-bit cache line requests onto a MIG-style DDR2 user interface.
//   Requests are queued in a small FIFO and executed one at a time, in arrival
//   order. Writebacks become one write command plus one single-beat data word.
//   Fills become one read command, and the returned line is reported with a
//   single-cycle ddr2_available pulse.
//
// Ports
//   clk, rstn            : clock (rising edge), asynchronous active-low reset
//   ddr2_enable/read     : cache request strobe and direction (1 = fill)
//   ddr2_addr            : line byte address, bits [3:0] ignored
//   to_ddr2_data         : writeback line, captured with the request
//   ddr2_available       : one-cycle pulse, ddr2_data holds a new fill line
//   ddr2_data            : last fill line, held until the next fill
//   init_calib_complete  : MIG calibration done, nothing is issued before it
//   app_*                : MIG user-interface command / write / read channels
//   busy                 : requests queued or a MIG transaction in flight
//   overflow             : sticky, a request arrived while the FIFO was full
module ddr2_line_bridge #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ddr2_enable,
  input  logic         ddr2_read,
  input  logic [26:0]  ddr2_addr,
  input  logic [127:0] to_ddr2_data,
  output logic         ddr2_available,
  output logic [127:0] ddr2_data,
  input  logic         init_calib_complete,
  output logic [26:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  input  logic         app_rdy,
  output logic [127:0] app_wdf_data,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  output logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid,
  output logic         busy,
  output logic         overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR      = 2'd1;
  localparam logic [1:0] S_RD_CMD  = 2'd2;
  localparam logic [1:0] S_RD_WAIT = 2'd3;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef struct packed {
    logic         rd;
    logic [22:0]  line;
    logic [127:0] data;
  } entry_t;

  // ---------------------------------------------------------------- FIFO
  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             fifo_empty, fifo_full, push, pop;
  entry_t           head;

  logic [1:0]   state_q, state_d;
  logic         app_en_q, app_en_d;
  logic [2:0]   app_cmd_q, app_cmd_d;
  logic [26:0]  app_addr_q, app_addr_d;
  logic [127:0] app_wdf_data_q, app_wdf_data_d;
  logic         app_wdf_wren_q, app_wdf_wren_d;
  logic [127:0] ddr2_data_q, ddr2_data_d;
  logic         avail_q, avail_d;
  logic         busy_q, busy_d;
  logic         overflow_q;

  // Line offset bits carry no information for a whole-line transfer.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ddr2_addr[3:0];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign pop        = (state_q == S_IDLE) && !fifo_empty && init_calib_complete;
  // A full FIFO still accepts a request in the cycle it pops one.
  assign push       = ddr2_enable && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage arrays carry no reset; only the pointers and count define
  // which entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{rd: ddr2_read, line: ddr2_addr[26:4], data: to_ddr2_data};
  end

  // ---------------------------------------------------------------- FSM
  // NOTE: every signal assigned here receives a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    app_en_d       = app_en_q;
    app_cmd_d      = app_cmd_q;
    app_addr_d     = app_addr_q;
    app_wdf_data_d = app_wdf_data_q;
    app_wdf_wren_d = app_wdf_wren_q;
    ddr2_data_d    = ddr2_data_q;
    avail_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          app_addr_d = {head.line, 4'b0000};
          app_en_d   = 1'b1;
          if (head.rd) begin
            app_cmd_d = CMD_READ;
            state_d   = S_RD_CMD;
          end else begin
            app_cmd_d      = CMD_WRITE;
            app_wdf_data_d = head.data;
            app_wdf_wren_d = 1'b1;
            state_d        = S_WR;
          end
        end
      end
      S_WR: begin
        // Command and data channels complete independently, in either order.
        if (app_rdy)     app_en_d       = 1'b0;
        if (app_wdf_rdy) app_wdf_wren_d = 1'b0;
        if (!app_en_d && !app_wdf_wren_d) state_d = S_IDLE;
      end
      S_RD_CMD: begin
        if (app_rdy) begin
          app_en_d = 1'b0;
          state_d  = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (app_rd_data_valid) begin
          ddr2_data_d = app_rd_data;
          avail_d     = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (count_d != '0) || (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= S_IDLE;
      app_en_q       <= 1'b0;
      app_cmd_q      <= '0;
      app_addr_q     <= '0;
      app_wdf_data_q <= '0;
      app_wdf_wren_q <= 1'b0;
      ddr2_data_q    <= '0;
      avail_q        <= 1'b0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q        <= count_d;
      state_q        <= state_d;
      app_en_q       <= app_en_d;
      app_cmd_q      <= app_cmd_d;
      app_addr_q     <= app_addr_d;
      app_wdf_data_q <= app_wdf_data_d;
      app_wdf_wren_q <= app_wdf_wren_d;
      ddr2_data_q    <= ddr2_data_d;
      avail_q        <= avail_d;
      busy_q         <= busy_d;
      if (ddr2_enable && !push) overflow_q <= 1'b1;
    end
  end

  assign app_en         = app_en_q;
  assign app_cmd        = app_cmd_q;
  assign app_addr       = app_addr_q;
  assign app_wdf_data   = app_wdf_data_q;
  assign app_wdf_wren   = app_wdf_wren_q;
  assign app_wdf_end    = app_wdf_wren_q;  // every line is a single data beat
  assign app_wdf_mask   = 16'h0000;
  assign ddr2_data      = ddr2_data_q;
  assign ddr2_available = avail_q;
  assign busy           = busy_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_ddr2_line_bridge.sv
// tb_ddr2_line_bridge
//   Directed scenarios for ddr2_line_bridge. Inputs change 1 ns after the
//   rising edge and outputs are read at that same point. A passive monitor
//   logs every accepted MIG command, accepted write word and fill pulse.
module tb_ddr2_line_bridge;

  logic         clk = 1'b0;
  logic         rstn;
  logic         ddr2_enable, ddr2_read;
  logic [26:0]  ddr2_addr;
  logic [127:0] to_ddr2_data;
  logic         ddr2_available;
  logic [127:0] ddr2_data;
  logic         init_calib_complete;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren, app_wdf_end;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         busy, overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [29:0]  cmd_log[$];   // {app_cmd, app_addr} per accepted command
  logic [127:0] wdata_log[$];
  logic [127:0] fill_log[$];
  int           avail_cnt = 0;

  localparam logic [127:0] FILL_A5 = {16{8'hA5}};
  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D3 = 128'hDEAD_BEEF_0000_FFFF_CAFE_F00D_1234_5678;
  localparam logic [127:0] D4 = 128'h4444_0000_0000_0000_0000_0000_0000_0004;
  localparam logic [127:0] D5 = 128'h5555_0000_0000_0000_0000_0000_0000_0005;

  ddr2_line_bridge #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rstn(rstn),
    .ddr2_enable(ddr2_enable), .ddr2_read(ddr2_read), .ddr2_addr(ddr2_addr),
    .to_ddr2_data(to_ddr2_data), .ddr2_available(ddr2_available), .ddr2_data(ddr2_data),
    .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rstn === 1'b1) begin
      if (app_en && app_rdy)           cmd_log.push_back({app_cmd, app_addr});
      if (app_wdf_wren && app_wdf_rdy) wdata_log.push_back(app_wdf_data);
      if (ddr2_available) begin
        avail_cnt++;
        fill_log.push_back(ddr2_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One request cycle; on return the request has been sampled (edge E = cyc).
  task automatic req(input logic rd, input logic [26:0] a, input logic [127:0] d);
    ddr2_enable  = 1'b1;
    ddr2_read    = rd;
    ddr2_addr    = a;
    to_ddr2_data = d;
    tick();
    ddr2_enable  = 1'b0;
  endtask

  // Waits for a read command about to be accepted, lets it be accepted, then
  // returns data on the very next cycle. Returns at the pulse sample point.
  task automatic serve_read(input logic [127:0] d, input int budget);
    int n;
    n = 0;
    while (!(app_en === 1'b1 && app_rdy === 1'b1 && app_cmd === 3'b001) && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL serve_read_timeout: got no read command expected one within %0d cycles", budget);
    end else begin
      tick();
      app_rd_data       = d;
      app_rd_data_valid = 1'b1;
      tick();
      app_rd_data_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({app_en, app_wdf_wren, app_wdf_end, ddr2_available, busy, overflow} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 000000",
               {app_en, app_wdf_wren, app_wdf_end, ddr2_available, busy, overflow});
    end
    n_cmp++;
    if ({app_addr, app_cmd, app_wdf_mask} !== 46'b0) begin
      n_err++;
      $display("FAIL reset_cmd: got addr %h cmd %b mask %h expected all 0", app_addr, app_cmd, app_wdf_mask);
    end
    n_cmp++;
    if ({app_wdf_data, ddr2_data} !== 256'b0) begin
      n_err++;
      $display("FAIL reset_data: got %h / %h expected 0", app_wdf_data, ddr2_data);
    end
    rstn = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({app_en, busy, overflow} !== 3'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: got %b expected 000", {app_en, busy, overflow});
    end
  endtask

  task automatic test_single_fill();
    int b_cmd, b_av, t0;
    b_cmd = cmd_log.size();
    b_av  = avail_cnt;
    req(1'b1, 27'h0012340, '0);
    t0 = cyc;
    n_cmp++;
    if (app_en !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL fill_at_E: got app_en %b busy %b expected app_en 0 busy 1", app_en, busy);
    end
    tick();
    n_cmp++;
    if ({app_en, app_cmd, app_addr} !== {1'b1, 3'b001, 27'h0012340}) begin
      n_err++;
      $display("FAIL fill_cmd_E1: got en %b cmd %b addr %h expected 1 001 0012340", app_en, app_cmd, app_addr);
    end
    serve_read(FILL_A5, 20);
    n_cmp++;
    if (cyc - t0 !== 3) begin
      n_err++;
      $display("FAIL fill_turnaround: got %0d expected 3 edges", cyc - t0);
    end
    n_cmp++;
    if (ddr2_available !== 1'b1 || ddr2_data !== FILL_A5) begin
      n_err++;
      $display("FAIL fill_pulse: got avail %b data %h expected 1 %h", ddr2_available, ddr2_data, FILL_A5);
    end
    tick();
    n_cmp++;
    if (ddr2_available !== 1'b0 || ddr2_data !== FILL_A5) begin
      n_err++;
      $display("FAIL fill_pulse_end: got avail %b data %h expected 0 %h", ddr2_available, ddr2_data, FILL_A5);
    end
    n_cmp++;
    if (cmd_log.size() !== b_cmd + 1 || cmd_log[b_cmd] !== {3'b001, 27'h0012340} || avail_cnt - b_av !== 1) begin
      n_err++;
      $display("FAIL fill_log: got %0d cmds %h, %0d pulses expected 1 cmd %h, 1 pulse",
               cmd_log.size() - b_cmd, cmd_log[b_cmd], avail_cnt - b_av, {3'b001, 27'h0012340});
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL fill_busy_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int b_cmd, b_wd, b_av;
    b_cmd = cmd_log.size();
    b_wd  = wdata_log.size();
    b_av  = avail_cnt;
    req(1'b0, 27'h0004560, D1);
    req(1'b1, 27'h0008560, '0);
    n_cmp++;
    if ({app_en, app_cmd, app_wdf_wren, app_wdf_end} !== {1'b1, 3'b000, 1'b1, 1'b1} || app_wdf_data !== D1) begin
      n_err++;
      $display("FAIL b2b_write_issue: got en %b cmd %b wren %b end %b data %h expected 1 000 1 1 %h",
               app_en, app_cmd, app_wdf_wren, app_wdf_end, app_wdf_data, D1);
    end
    serve_read(D2, 20);
    n_cmp++;
    if (ddr2_available !== 1'b1 || ddr2_data !== D2) begin
      n_err++;
      $display("FAIL b2b_fill: got avail %b data %h expected 1 %h", ddr2_available, ddr2_data, D2);
    end
    tick();
    tick();
    n_cmp++;
    if (cmd_log.size() !== b_cmd + 2 || cmd_log[b_cmd] !== {3'b000, 27'h0004560}
        || cmd_log[b_cmd+1] !== {3'b001, 27'h0008560}) begin
      n_err++;
      $display("FAIL b2b_order: got %0d cmds %h %h expected 2 cmds %h %h", cmd_log.size() - b_cmd,
               cmd_log[b_cmd], cmd_log[b_cmd+1], {3'b000, 27'h0004560}, {3'b001, 27'h0008560});
    end
    n_cmp++;
    if (wdata_log.size() !== b_wd + 1 || wdata_log[b_wd] !== D1) begin
      n_err++;
      $display("FAIL b2b_wdata: got %0d words %h expected 1 word %h", wdata_log.size() - b_wd, wdata_log[b_wd], D1);
    end
    n_cmp++;
    if (avail_cnt - b_av !== 1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_pulses_overflow: got %0d pulses overflow %b expected 1 pulse overflow 0",
               avail_cnt - b_av, overflow);
    end
  endtask

  task automatic test_backpressure();
    int b_cmd, b_wd, en_cnt, wr_cnt;
    logic stable;
    b_cmd  = cmd_log.size();
    b_wd   = wdata_log.size();
    en_cnt = 0;
    wr_cnt = 0;
    stable = 1'b1;
    app_rdy     = 1'b0;
    app_wdf_rdy = 1'b0;
    req(1'b0, 27'h0ABCDE0, D3);
    tick();
    for (int k = 0; k < 12; k++) begin
      if (app_en === 1'b1) begin
        en_cnt++;
        if (app_addr !== 27'h0ABCDE0 || app_cmd !== 3'b000) stable = 1'b0;
      end
      if (app_wdf_wren === 1'b1) begin
        wr_cnt++;
        if (app_wdf_data !== D3 || app_wdf_end !== 1'b1) stable = 1'b0;
      end
      app_wdf_rdy = (k >= 3);
      app_rdy     = (k >= 5);
      tick();
    end
    n_cmp++;
    if (en_cnt !== 6) begin
      n_err++;
      $display("FAIL bp_app_en_cycles: got %0d expected 6", en_cnt);
    end
    n_cmp++;
    if (wr_cnt !== 4) begin
      n_err++;
      $display("FAIL bp_wren_cycles: got %0d expected 4", wr_cnt);
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_err++;
      $display("FAIL bp_stable: got %b expected 1", stable);
    end
    n_cmp++;
    if (cmd_log.size() !== b_cmd + 1 || cmd_log[b_cmd] !== {3'b000, 27'h0ABCDE0}
        || wdata_log.size() !== b_wd + 1 || wdata_log[b_wd] !== D3) begin
      n_err++;
      $display("FAIL bp_single_write: got %0d cmds %0d words expected 1 write of %h at 0ABCDE0",
               cmd_log.size() - b_cmd, wdata_log.size() - b_wd, D3);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_busy_end: got %b expected 0", busy);
    end
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
  endtask

  // Line addresses with non-zero offset bits must reach the MIG line-aligned.
  task automatic test_calib_gating();
    int b_cmd, b_fill;
    logic seen_en;
    b_cmd   = cmd_log.size();
    b_fill  = fill_log.size();
    seen_en = 1'b0;
    init_calib_complete = 1'b0;
    req(1'b1, 27'h0011117, '0);
    req(1'b1, 27'h002222F, '0);
    for (int k = 0; k < 5; k++) begin
      if (app_en !== 1'b0) seen_en = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen_en !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL calib_hold: got app_en seen %b busy %b expected 0 1", seen_en, busy);
    end
    init_calib_complete = 1'b1;
    serve_read(D4, 10);
    n_cmp++;
    if (ddr2_available !== 1'b1 || ddr2_data !== D4) begin
      n_err++;
      $display("FAIL calib_fill1: got avail %b data %h expected 1 %h", ddr2_available, ddr2_data, D4);
    end
    serve_read(D5, 10);
    n_cmp++;
    if (ddr2_available !== 1'b1 || ddr2_data !== D5) begin
      n_err++;
      $display("FAIL calib_fill2: got avail %b data %h expected 1 %h", ddr2_available, ddr2_data, D5);
    end
    tick();
    n_cmp++;
    if (cmd_log.size() !== b_cmd + 2 || cmd_log[b_cmd] !== {3'b001, 27'h0011110}
        || cmd_log[b_cmd+1] !== {3'b001, 27'h0022220}) begin
      n_err++;
      $display("FAIL calib_order: got %0d cmds %h %h expected %h %h", cmd_log.size() - b_cmd,
               cmd_log[b_cmd], cmd_log[b_cmd+1], {3'b001, 27'h0011110}, {3'b001, 27'h0022220});
    end
    n_cmp++;
    if (fill_log.size() !== b_fill + 2 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL calib_pulses: got %0d pulses overflow %b expected 2 pulses overflow 0",
               fill_log.size() - b_fill, overflow);
    end
  endtask

  // A stalled read occupies the engine first, so the FIFO really is the only
  // buffer left: of the three back-to-back requests, the third cannot fit.
  task automatic test_overflow();
    int b_cmd, b_av;
    b_cmd = cmd_log.size();
    b_av  = avail_cnt;
    app_rdy = 1'b0;
    req(1'b1, 27'h0100000, '0);
    tick();
    tick();
    req(1'b1, 27'h0200010, '0);
    req(1'b1, 27'h0300020, '0);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_early: got %b expected 0", overflow);
    end
    req(1'b1, 27'h0400030, '0);
    n_cmp++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: got overflow %b busy %b expected 1 1", overflow, busy);
    end
    app_rdy = 1'b1;
    serve_read(D1, 10);
    serve_read(D2, 10);
    serve_read(D3, 10);
    tick();
    tick();
    tick();
    n_cmp++;
    if (cmd_log.size() !== b_cmd + 3 || cmd_log[b_cmd] !== {3'b001, 27'h0100000}
        || cmd_log[b_cmd+1] !== {3'b001, 27'h0200010} || cmd_log[b_cmd+2] !== {3'b001, 27'h0300020}) begin
      n_err++;
      $display("FAIL ovf_order: got %0d cmds %h %h %h expected 0100000 0200010 0300020 (cmd 001)",
               cmd_log.size() - b_cmd, cmd_log[b_cmd], cmd_log[b_cmd+1], cmd_log[b_cmd+2]);
    end
    n_cmp++;
    if (avail_cnt - b_av !== 3 || fill_log[fill_log.size()-1] !== D3) begin
      n_err++;
      $display("FAIL ovf_fills: got %0d pulses expected 3", avail_cnt - b_av);
    end
    n_cmp++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_sticky: got overflow %b busy %b expected 1 0", overflow, busy);
    end
  endtask

  task automatic test_reset_rd_wait();
    int b_av;
    logic seen;
    b_av = avail_cnt;
    seen = 1'b0;
    req(1'b1, 27'h0555550, '0);
    req(1'b1, 27'h0666660, '0);
    tick();
    n_cmp++;
    if (app_en !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_state: got app_en %b busy %b expected 0 1", app_en, busy);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({app_en, app_cmd, app_addr, busy, overflow, ddr2_available} !== 34'b0 || ddr2_data !== 128'b0) begin
      n_err++;
      $display("FAIL rst_async_clear: got en %b cmd %b addr %h busy %b ovf %b data %h expected all 0",
               app_en, app_cmd, app_addr, busy, overflow, ddr2_data);
    end
    tick();
    rstn = 1'b1;
    app_rd_data       = D5;
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (ddr2_available !== 1'b0 || app_en !== 1'b0) seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen !== 1'b0 || avail_cnt !== b_av) begin
      n_err++;
      $display("FAIL rst_no_activity: got activity %b pulses %0d expected 0 0", seen, avail_cnt - b_av);
    end
    n_cmp++;
    if (ddr2_data !== 128'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL rst_outputs_zero: got data %h busy %b ovf %b expected 0 0 0", ddr2_data, busy, overflow);
    end
  endtask

  initial begin
    rstn                = 1'b0;
    ddr2_enable         = 1'b0;
    ddr2_read           = 1'b0;
    ddr2_addr           = '0;
    to_ddr2_data        = '0;
    init_calib_complete = 1'b1;
    app_rdy             = 1'b1;
    app_wdf_rdy         = 1'b1;
    app_rd_data         = '0;
    app_rd_data_valid   = 1'b0;
    #1;
    test_reset();
    test_single_fill();
    test_back_to_back();
    test_backpressure();
    test_calib_gating();
    test_overflow();
    test_reset_rd_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
